// File: rtl/clk_gate_pkg.sv
// Shared types and sizing helpers for the clock-gate controller.
package clk_gate_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_IDLE_WAIT = 3'd1,
        ST_SLEEP_REQ = 3'd2,
        ST_GATED     = 3'd3,
        ST_WAKE      = 3'd4
    } cg_state_e;

    localparam int SLEEP_CNT_W = 16;

    // Timer width large enough to hold the larger of the two reload values.
    function automatic int cnt_width(input int idle, input int wake);
        return $clog2(((idle > wake) ? idle : wake) + 1);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl_timer.sv
// Down-counter shared by the idle window and the wake settling phase.
module gate_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    // Load has priority; decrement stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_gate_ctrl.sv
// Clock-gate enable controller: idle detection, sleep handshake, gated
// hold-off and timed wake. All outputs are dedicated flops.
module clk_gate_ctrl
    import clk_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   busy,
    input  logic                   wake_req,
    input  logic                   force_on,
    input  logic                   sleep_ack,
    output logic                   sleep_req,
    output logic                   clk_en,
    output logic                   awake,
    output logic [SLEEP_CNT_W-1:0] sleep_count
);

    localparam int CNT_W = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LD = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LD = CNT_W'(WAKE_CYCLES - 1);

    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("clk_gate_ctrl: IDLE_CYCLES must be >= 1");
    end
    if (WAKE_CYCLES < 1) begin : g_bad_wake
        $error("clk_gate_ctrl: WAKE_CYCLES must be >= 1");
    end

    cg_state_e              state_q, state_d;
    logic                   tmr_load, tmr_dec, tmr_zero;
    logic [CNT_W-1:0]       tmr_val;
    logic                   cnt_inc;
    logic                   clk_en_q, awake_q, sleep_req_q;
    logic                   clk_en_d, awake_d, sleep_req_d;
    logic [SLEEP_CNT_W-1:0] sleep_cnt_q;

    logic stay, wake;
    assign stay = busy | wake_req | force_on;
    assign wake = wake_req | force_on;

    gate_timer #(.W(CNT_W)) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    // Next-state, timer control, and output decode of the next state so the
    // output flops change together with the state register.
    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        tmr_dec  = 1'b0;
        cnt_inc  = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (!stay) begin
                    state_d  = ST_IDLE_WAIT;
                    tmr_load = 1'b1;
                    tmr_val  = IDLE_LD;
                end
            end
            ST_IDLE_WAIT: begin
                if (stay)          state_d = ST_RUN;
                else if (tmr_zero) state_d = ST_SLEEP_REQ;
                else               tmr_dec = 1'b1;
            end
            ST_SLEEP_REQ: begin
                // Abort beats a coincident acknowledge.
                if (stay) begin
                    state_d = ST_RUN;
                end else if (sleep_ack) begin
                    state_d = ST_GATED;
                    cnt_inc = 1'b1;
                end
            end
            ST_GATED: begin
                if (wake) begin
                    state_d  = ST_WAKE;
                    tmr_load = 1'b1;
                    tmr_val  = WAKE_LD;
                end
            end
            ST_WAKE: begin
                // Wake runs to completion even if the request drops.
                if (tmr_zero) state_d = ST_RUN;
                else          tmr_dec = 1'b1;
            end
            default: state_d = ST_RUN;
        endcase
        clk_en_d    = (state_d != ST_GATED);
        awake_d     = (state_d == ST_RUN) || (state_d == ST_IDLE_WAIT) ||
                      (state_d == ST_SLEEP_REQ);
        sleep_req_d = (state_d == ST_SLEEP_REQ) || (state_d == ST_GATED) ||
                      (state_d == ST_WAKE);
    end

    // State and output flops; reset restores the running clock immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            clk_en_q    <= 1'b1;
            awake_q     <= 1'b1;
            sleep_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clk_en_q    <= clk_en_d;
            awake_q     <= awake_d;
            sleep_req_q <= sleep_req_d;
        end
    end

    // Saturating count of entries into the gated state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sleep_cnt_q <= '0;
        end else if (cnt_inc && (sleep_cnt_q != '1)) begin
            sleep_cnt_q <= sleep_cnt_q + 1'b1;
        end
    end

    assign clk_en      = clk_en_q;
    assign awake       = awake_q;
    assign sleep_req   = sleep_req_q;
    assign sleep_count = sleep_cnt_q;

endmodule
